// File: rtl/triumph_id_stage_pkg.sv
// Types and the RV32I ALU-subset decoder shared by the triumph ID stage.
`include "triumph_riscv_defines.sv"

package triumph_id_stage_pkg;

    typedef enum logic [1:0] {
        FmtNone,
        FmtReg,
        FmtImm
    } id_fmt_e;

    typedef struct packed {
        id_fmt_e     fmt;
        logic [6:0]  op_type;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } id_dec_t;

    // FmtNone marks anything outside the supported ALU subset.
    function automatic id_dec_t id_decode(input logic [31:0] instr);
        id_dec_t    dec;
        logic [2:0] funct3;
        logic [6:0] funct7;
        funct3      = instr[14:12];
        funct7      = instr[31:25];
        dec.fmt     = FmtNone;
        dec.op_type = `ALU_NOP;
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.imm     = {{20{instr[31]}}, instr[31:20]};
        case (instr[6:0])
            `OPCODE_OP: begin
                if (funct7 == `FUNCT7_BASE) begin
                    case (funct3)
                        `FUNCT3_ADD_SUB: dec.op_type = `ALU_ADD;
                        `FUNCT3_XOR:     dec.op_type = `ALU_XOR;
                        `FUNCT3_OR:      dec.op_type = `ALU_OR;
                        `FUNCT3_AND:     dec.op_type = `ALU_AND;
                        default:         dec.op_type = `ALU_NOP;
                    endcase
                end else if (funct7 == `FUNCT7_SUB && funct3 == `FUNCT3_ADD_SUB) begin
                    dec.op_type = `ALU_SUB;
                end
                if (dec.op_type != `ALU_NOP) dec.fmt = FmtReg;
            end
            `OPCODE_OPIMM: begin
                case (funct3)
                    `FUNCT3_ADD_SUB: dec.op_type = `ALU_ADD;
                    `FUNCT3_XOR:     dec.op_type = `ALU_XOR;
                    `FUNCT3_OR:      dec.op_type = `ALU_OR;
                    `FUNCT3_AND:     dec.op_type = `ALU_AND;
                    default:         dec.op_type = `ALU_NOP;
                endcase
                if (dec.op_type != `ALU_NOP) dec.fmt = FmtImm;
            end
            default: dec.fmt = FmtNone;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/triumph_regfile.sv
// Architectural register file: two combinational read ports, one synchronous write port, x0 = 0.
module triumph_regfile #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic [4:0]      raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [4:0]      raddr_b,
    output logic [XLEN-1:0] rdata_b,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] mem [NUM_REGS];

    // No reset: contents survive rst_i of the stage.
    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/triumph_riscv_defines.sv
// Shared RV32I decode constants: ALU op_type codes and the OP / OP-IMM encodings.
`ifndef TRIUMPH_RISCV_DEFINES_SV
`define TRIUMPH_RISCV_DEFINES_SV

`define ALU_NOP        7'b0000000
`define ALU_ADD        7'b0011000
`define ALU_SUB        7'b0011001
`define ALU_XOR        7'b0101111
`define ALU_OR         7'b0101110
`define ALU_AND        7'b0010101

`define OPCODE_OP      7'h33
`define OPCODE_OPIMM   7'h13

`define FUNCT3_ADD_SUB 3'b000
`define FUNCT3_XOR     3'b100
`define FUNCT3_OR      3'b110
`define FUNCT3_AND     3'b111

`define FUNCT7_BASE    7'b0000000
`define FUNCT7_SUB     7'b0100000

`endif

// File: rtl/triumph_id_stage.sv
// RV32I decode stage with scoreboard hazard stalls feeding EX.
// Define TRIUMPH_ID_WB_BYPASS_EN to forward same-cycle writeback data into the operands.
`include "triumph_riscv_defines.sv"

module triumph_id_stage
    import triumph_id_stage_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            instr_valid_i,
    input  logic [31:0]     instr_i,
    output logic            instr_ready_o,
    output logic [XLEN-1:0] op1_data_o,
    output logic [XLEN-1:0] op2_data_o,
    output logic [6:0]      op_type_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic            illegal_o,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i
);

    logic                id_full_q, id_full_d;
    logic [31:0]         instr_q, instr_d;
    logic [NUM_REGS-1:0] sb_q, sb_d;

    id_dec_t             dec;
    logic                legal, is_reg, stall, issue;
    logic [XLEN-1:0]     rf_rs1, rf_rs2, rs1_val, rs2_val;
    logic [NUM_REGS-1:0] wb_hit, busy;

    assign dec    = id_decode(instr_q);
    assign legal  = (dec.fmt != FmtNone);
    assign is_reg = (dec.fmt == FmtReg);

    triumph_regfile #(
        .NUM_REGS (NUM_REGS),
        .XLEN     (XLEN)
    ) u_regfile (
        .clk      (clk_i),
        .raddr_a  (dec.rs1),
        .rdata_a  (rf_rs1),
        .raddr_b  (dec.rs2),
        .rdata_b  (rf_rs2),
        .we       (wb_we_i),
        .waddr    (wb_addr_i),
        .wdata    (wb_data_i)
    );

    always_comb begin
        wb_hit = '0;
        if (wb_we_i) wb_hit[wb_addr_i] = 1'b1;
    end

`ifdef TRIUMPH_ID_WB_BYPASS_EN
    // A register being written back this cycle is already available to issue.
    assign busy    = sb_q & ~wb_hit;
    assign rs1_val = (wb_hit[dec.rs1] && dec.rs1 != 5'd0) ? wb_data_i : rf_rs1;
    assign rs2_val = (wb_hit[dec.rs2] && dec.rs2 != 5'd0) ? wb_data_i : rf_rs2;
`else
    assign busy    = sb_q;
    assign rs1_val = rf_rs1;
    assign rs2_val = rf_rs2;
`endif

    // rs2 only matters for register-register ops; rd covers WAW ordering.
    assign stall = id_full_q && legal &&
                   (busy[dec.rs1] || (is_reg && busy[dec.rs2]) || busy[dec.rd]);
    assign issue = id_full_q && legal && !stall;

    assign instr_ready_o = !id_full_q || issue;
    assign illegal_o     = id_full_q && !legal;

    always_comb begin
        op1_data_o = '0;
        op2_data_o = '0;
        op_type_o  = `ALU_NOP;
        rd_addr_o  = 5'd0;
        rd_we_o    = 1'b0;
        if (issue) begin
            op1_data_o = rs1_val;
            op2_data_o = is_reg ? rs2_val : XLEN'($signed(dec.imm));
            op_type_o  = dec.op_type;
            rd_addr_o  = dec.rd;
            rd_we_o    = (dec.rd != 5'd0);
        end
    end

    always_comb begin
        id_full_d = id_full_q;
        instr_d   = instr_q;
        if (issue || illegal_o) begin
            id_full_d = 1'b0;
        end
        if (instr_valid_i && instr_ready_o) begin
            id_full_d = 1'b1;
            instr_d   = instr_i;
        end

        // Clear before set so an issue to the register being retired keeps it busy.
        sb_d = sb_q & ~wb_hit;
        if (issue && dec.rd != 5'd0) begin
            sb_d[dec.rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_full_q <= 1'b0;
            instr_q   <= '0;
            sb_q      <= '0;
        end else begin
            id_full_q <= id_full_d;
            instr_q   <= instr_d;
            sb_q      <= sb_d;
        end
    end

endmodule

// File: tb/tb_triumph_id_stage.sv
// Self-checking bench for triumph_id_stage against a table-driven behavioural model.
`ifndef TRIUMPH_RISCV_DEFINES_SV
`include "triumph_riscv_defines.sv"
`endif

module tb_triumph_id_stage;

`ifdef TRIUMPH_ID_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] op1, op2;
    logic [6:0]  op_type;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    triumph_id_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_valid_i (instr_valid),
        .instr_i       (instr),
        .instr_ready_o (instr_ready),
        .op1_data_o    (op1),
        .op2_data_o    (op2),
        .op_type_o     (op_type),
        .rd_addr_o     (rd_addr),
        .rd_we_o       (rd_we),
        .illegal_o     (illegal),
        .wb_we_i       (wb_we),
        .wb_addr_i     (wb_addr),
        .wb_data_i     (wb_data)
    );

    // Supported instruction table: opcode, funct3, whether funct7 is checked, funct7, ALU code.
    typedef struct packed {
        logic [6:0] opc;
        logic [2:0] f3;
        logic       chk_f7;
        logic [6:0] f7;
        logic [6:0] code;
    } op_row_t;
    op_row_t op_tab [9];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit          held;
    logic [31:0] hinst;
    logic [31:0] regs [32];
    bit          busy [32];
    bit          pv   [32];
    int          pc   [32];
    logic [31:0] pd   [32];
    bit          rand_wb, auto_wb;
    int          wb_delay;
    bit          fwb;
    logic [4:0]  fwb_a;
    logic [31:0] fwb_d;

    bit          last_ok, last_ill, last_ready, last_rd_we;
    logic [6:0]  last_code;
    logic [31:0] last_op1, last_op2;
    int          last_issue_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [6:0] ref_code(input logic [31:0] ins, output bit is_r);
        logic [6:0] code;
        code = 7'd0;
        is_r = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (ins[6:0] == op_tab[i].opc && ins[14:12] == op_tab[i].f3 &&
                (!op_tab[i].chk_f7 || ins[31:25] == op_tab[i].f7)) begin
                code = op_tab[i].code;
                is_r = (op_tab[i].opc == 7'h33);
            end
        end
        return code;
    endfunction

    function automatic logic [31:0] alu(input logic [6:0] code, input logic [31:0] a,
                                        input logic [31:0] b);
        if (code == `ALU_ADD) return a + b;
        if (code == `ALU_SUB) return a - b;
        if (code == `ALU_XOR) return a ^ b;
        if (code == `ALU_OR)  return a | b;
        return a & b;
    endfunction

    function automatic bit avail(input logic [4:0] x, input bit wbe, input logic [4:0] wba);
        return (x == 5'd0) || !busy[x] || (BYPASS && wbe && wba == x);
    endfunction

    function automatic logic [31:0] rv(input logic [4:0] x, input bit wbe,
                                       input logic [4:0] wba, input logic [31:0] wbd);
        if (x == 5'd0) return 32'd0;
        if (BYPASS && wbe && wba == x) return wbd;
        return regs[x];
    endfunction

    // One clock cycle: drive at negedge, check model vs DUT, advance model at posedge.
    task automatic step(input bit r, input bit v, input logic [31:0] ins);
        logic [6:0]  code;
        bit          is_r, legal, ok, ill, exp_ready, wbe;
        logic [4:0]  rd, rs1, rs2, wba;
        logic [31:0] a, b, imm, wbd;
        int          k;
        rst = r;
        instr_valid = v;
        instr = ins;
        wbe = 1'b0; wba = 5'd0; wbd = 32'd0;
        if (fwb) begin
            wbe = 1'b1; wba = fwb_a; wbd = fwb_d; fwb = 1'b0;
        end else if (!r) begin
            for (int j = 1; j < 32; j++) begin
                if (!wbe && pv[j] && pc[j] <= 0) begin
                    wbe = 1'b1; wba = 5'(j); wbd = pd[j]; pv[j] = 1'b0;
                end
            end
            if (!wbe && rand_wb && $urandom_range(7) == 0) begin
                k = $urandom_range(7);
                if (!pv[k] && !busy[k]) begin
                    wbe = 1'b1; wba = 5'(k); wbd = $urandom;
                end
            end
        end
        for (int j = 1; j < 32; j++) if (pv[j] && pc[j] > 0) pc[j]--;
        wb_we = wbe; wb_addr = wba; wb_data = wbd;
        #1;
        code = ref_code(hinst, is_r);
        legal = (code != 7'd0);
        rd = hinst[11:7]; rs1 = hinst[19:15]; rs2 = hinst[24:20];
        imm = {{20{hinst[31]}}, hinst[31:20]};
        ok = held && legal && avail(rs1, wbe, wba) && (!is_r || avail(rs2, wbe, wba)) &&
             avail(rd, wbe, wba);
        ill = held && !legal;
        exp_ready = !held || ok;
        a = rv(rs1, wbe, wba, wbd);
        b = is_r ? rv(rs2, wbe, wba, wbd) : imm;
        if (!r) begin
            check("ready", 32'(instr_ready), 32'(exp_ready));
            check("op_type", 32'(op_type), ok ? 32'(code) : 32'd0);
            check("rd_we", 32'(rd_we), 32'(ok && rd != 5'd0));
            check("illegal", 32'(illegal), 32'(ill));
            check("op1", op1, ok ? a : 32'd0);
            check("op2", op2, ok ? b : 32'd0);
            if (ok) check("rd_addr", 32'(rd_addr), 32'(rd));
        end
        last_ok = ok; last_ill = illegal; last_ready = instr_ready; last_rd_we = rd_we;
        last_code = op_type; last_op1 = op1; last_op2 = op2;
        if (ok) last_issue_cyc = cyc;
        @(posedge clk);
        if (wbe && wba != 5'd0) regs[wba] = wbd;
        if (r) begin
            held = 1'b0;
            for (int j = 0; j < 32; j++) begin busy[j] = 1'b0; pv[j] = 1'b0; end
        end else begin
            if (wbe) busy[wba] = 1'b0;
            if (ok && rd != 5'd0) begin
                busy[rd] = 1'b1;
                if (auto_wb) begin
                    pv[rd] = 1'b1;
                    pc[rd] = (wb_delay < 0) ? $urandom_range(3) : wb_delay;
                    pd[rd] = alu(code, a, b);
                end
            end
            if (ok || ill) held = 1'b0;
            if (exp_ready && v) begin held = 1'b1; hinst = ins; end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        bit done;
        bit any;
        done = 1'b0;
        for (int t = 0; t < 60 && !done; t++) begin
            any = 1'b0;
            for (int j = 0; j < 32; j++) any |= pv[j];
            if (!held && !any) done = 1'b1;
            else step(1'b0, 1'b0, 32'd0);
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue_one(input logic [31:0] ins, output int nsteps);
        bit done;
        done = 1'b0;
        step(1'b0, 1'b1, ins);
        nsteps = 1;
        for (int t = 0; t < 20 && !done; t++) begin
            step(1'b0, 1'b0, 32'd0);
            nsteps++;
            if (last_ok) done = 1'b1;
        end
        if (!done) check("issue_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        int          sel;
        rd = 5'($urandom_range(7)); rs1 = 5'($urandom_range(7)); rs2 = 5'($urandom_range(7));
        imm = 12'($urandom);
        sel = $urandom_range(9);
        if (sel < 4) begin
            case ($urandom_range(4))
                0: return r_ins(7'h00, rs2, rs1, 3'd0, rd);
                1: return r_ins(7'h20, rs2, rs1, 3'd0, rd);
                2: return r_ins(7'h00, rs2, rs1, 3'd4, rd);
                3: return r_ins(7'h00, rs2, rs1, 3'd6, rd);
                default: return r_ins(7'h00, rs2, rs1, 3'd7, rd);
            endcase
        end
        if (sel < 8) begin
            case ($urandom_range(3))
                0: return i_ins(imm, rs1, 3'd0, rd);
                1: return i_ins(imm, rs1, 3'd4, rd);
                2: return i_ins(imm, rs1, 3'd6, rd);
                default: return i_ins(imm, rs1, 3'd7, rd);
            endcase
        end
        if (sel == 8) return ($urandom_range(1) == 0) ? 32'h0000_0073 : $urandom;
        return ($urandom_range(1) == 0) ? r_ins(7'h01, rs2, rs1, 3'd0, rd)
                                        : i_ins(imm, rs1, 3'd1, rd);
    endfunction

    initial begin
        int n, c0, cnt;
        op_tab[0] = '{7'h33, 3'd0, 1'b1, 7'h00, `ALU_ADD};
        op_tab[1] = '{7'h33, 3'd0, 1'b1, 7'h20, `ALU_SUB};
        op_tab[2] = '{7'h33, 3'd4, 1'b1, 7'h00, `ALU_XOR};
        op_tab[3] = '{7'h33, 3'd6, 1'b1, 7'h00, `ALU_OR};
        op_tab[4] = '{7'h33, 3'd7, 1'b1, 7'h00, `ALU_AND};
        op_tab[5] = '{7'h13, 3'd0, 1'b0, 7'h00, `ALU_ADD};
        op_tab[6] = '{7'h13, 3'd4, 1'b0, 7'h00, `ALU_XOR};
        op_tab[7] = '{7'h13, 3'd6, 1'b0, 7'h00, `ALU_OR};
        op_tab[8] = '{7'h13, 3'd7, 1'b0, 7'h00, `ALU_AND};
        held = 1'b0; hinst = 32'd0; fwb = 1'b0; fwb_a = 5'd0; fwb_d = 32'd0;
        rand_wb = 1'b0; auto_wb = 1'b1; wb_delay = -1; last_issue_cyc = 0;
        for (int j = 0; j < 32; j++) begin
            regs[j] = 32'd0; busy[j] = 1'b0; pv[j] = 1'b0; pc[j] = 0; pd[j] = 32'd0;
        end
        rst = 1'b1; instr_valid = 1'b0; instr = 32'd0;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        @(negedge clk);

        // Preload the register file while reset is held (reset does not clear it).
        for (int k = 1; k < 32; k++) begin
            fwb = 1'b1; fwb_a = 5'(k); fwb_d = $urandom;
            step(1'b1, 1'b0, 32'd0);
        end
        step(1'b1, 1'b1, i_ins(12'd9, 5'd0, 3'd0, 5'd1));
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_op_type", 32'(op_type), 32'd0);
        check("rst_rd_we", 32'(rd_we), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_op1", op1, 32'd0);
        check("rst_op2", op2, 32'd0);

        // ADDI x1,x0,5 then dependent ADD x2,x1,x1 with a fixed writeback delay.
        wb_delay = 2;
        step(1'b0, 1'b1, i_ins(12'd5, 5'd0, 3'd0, 5'd1));
        step(1'b0, 1'b1, r_ins(7'h00, 5'd1, 5'd1, 3'd0, 5'd2));
        check("addi_op1", last_op1, 32'd0);
        check("addi_op2", last_op2, 32'd5);
        check("addi_code", 32'(last_code), 32'(`ALU_ADD));
        c0 = last_issue_cyc;
        n = 0;
        for (int t = 0; t < 20 && n == 0; t++) begin
            step(1'b0, 1'b0, 32'd0);
            if (last_ok) n = 1;
        end
        check("add_issued", 32'(n), 32'd1);
        check("add_op1", last_op1, 32'd5);
        check("add_op2", last_op2, 32'd5);
        check("add_stall_gap", 32'(last_issue_cyc - c0), BYPASS ? 32'd3 : 32'd4);
        wb_delay = -1;
        drain();

        // Sign-extended immediates.
        issue_one(i_ins(12'hfff, 5'd0, 3'd4, 5'd3), n);
        check("xori_op2", last_op2, 32'hffff_ffff);
        check("xori_code", 32'(last_code), 32'(`ALU_XOR));
        issue_one(i_ins(12'h800, 5'd0, 3'd7, 5'd4), n);
        check("andi_op2", last_op2, 32'hffff_f800);
        check("andi_code", 32'(last_code), 32'(`ALU_AND));
        drain();

        // x0 ignores writes and never gets rd_we.
        fwb = 1'b1; fwb_a = 5'd0; fwb_d = 32'h1234;
        step(1'b0, 1'b0, 32'd0);
        issue_one(i_ins(12'd0, 5'd0, 3'd0, 5'd7), n);
        check("x0_read", last_op1, 32'd0);
        issue_one(r_ins(7'h00, 5'd1, 5'd1, 3'd0, 5'd0), n);
        check("x0_rd_we", 32'(last_rd_we), 32'd0);
        drain();

        // Illegal word dropped with a single-cycle pulse.
        step(1'b0, 1'b1, 32'h0000_0073);
        step(1'b0, 1'b1, i_ins(12'd1, 5'd0, 3'd0, 5'd5));
        check("ill_pulse", 32'(last_ill), 32'd1);
        check("ill_op_type", 32'(last_code), 32'd0);
        check("ill_ready", 32'(last_ready), 32'd0);
        step(1'b0, 1'b1, i_ins(12'd1, 5'd0, 3'd0, 5'd5));
        check("ill_gone", 32'(last_ill), 32'd0);
        check("ill_next_ready", 32'(last_ready), 32'd1);
        step(1'b0, 1'b0, 32'd0);
        check("ill_next_issue", 32'(last_code), 32'(`ALU_ADD));
        drain();

        // Back-to-back independent ops.
        cnt = 0;
        step(1'b0, 1'b1, i_ins(12'd4, 5'd0, 3'd0, 5'd4));
        step(1'b0, 1'b1, i_ins(12'd5, 5'd0, 3'd6, 5'd5));
        cnt += int'(last_ok);
        step(1'b0, 1'b1, i_ins(12'd6, 5'd0, 3'd4, 5'd6));
        cnt += int'(last_ok);
        step(1'b0, 1'b0, 32'd0);
        cnt += int'(last_ok);
        check("b2b_issues", 32'(cnt), 32'd3);
        drain();

        // Reset during a stall drops the held op and clears the scoreboard.
        auto_wb = 1'b0;
        step(1'b0, 1'b1, i_ins(12'd7, 5'd0, 3'd0, 5'd1));
        step(1'b0, 1'b1, r_ins(7'h00, 5'd1, 5'd1, 3'd0, 5'd2));
        step(1'b0, 1'b0, 32'd0);
        check("stall_ready", 32'(last_ready), 32'd0);
        check("stall_op_type", 32'(last_code), 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("rst_stall_ready", 32'(instr_ready), 32'd1);
        auto_wb = 1'b1;
        issue_one(r_ins(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), n);
        check("post_rst_no_stall", 32'(n), 32'd2);
        fwb = 1'b1; fwb_a = 5'd1; fwb_d = 32'h99;
        step(1'b0, 1'b0, 32'd0);
        drain();
        issue_one(r_ins(7'h00, 5'd1, 5'd1, 3'd0, 5'd3), n);
        check("post_rst_wb", last_op1, 32'h99);
        drain();

        // Randomized traffic against the model.
        rand_wb = 1'b1;
        for (int t = 0; t < 600; t++) begin
            step(1'b0, ($urandom_range(3) != 0), rand_instr());
        end
        rand_wb = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
